// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 3x3 convolution MAC: walks every valid output pixel, issuing taps and handing results to writeback.
// Optional stall counter port enabled by defining CONV_SEQ_STALL_CNT_EN.
module conv_seq_ctrl #(
   parameter int IMG_W   = 8,
   parameter int IMG_H   = 8,
   parameter int K       = 3,
   parameter int ADDR_W  = 8,
   parameter int WADDR_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  ifm_addr,
   output logic [WADDR_W-1:0] wgt_addr,
   output logic               mac_en,
   output logic               mac_clr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_addr
`ifdef CONV_SEQ_STALL_CNT_EN
   ,
   output logic [15:0]        stall_cnt
`endif
);

   localparam int OW = IMG_W - K + 1;
   localparam int OH = IMG_H - K + 1;
   localparam logic [WADDR_W-1:0] KLAST  = WADDR_W'(K - 1);
   localparam logic [ADDR_W-1:0]  OWLAST = ADDR_W'(OW - 1);
   localparam logic [ADDR_W-1:0]  OHLAST = ADDR_W'(OH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  orow_q, orow_d, ocol_q, ocol_d;
   logic [WADDR_W-1:0] kr_q, kr_d, kc_q, kc_d;

   logic               busy_d, done_d, mac_en_d, mac_clr_d, out_valid_d;
   logic [ADDR_W-1:0]  ifm_addr_d, out_addr_d;
   logic [WADDR_W-1:0] wgt_addr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         orow_q    <= '0;
         ocol_q    <= '0;
         kr_q      <= '0;
         kc_q      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
         out_valid <= 1'b0;
         ifm_addr  <= '0;
         wgt_addr  <= '0;
         out_addr  <= '0;
      end else begin
         state_q   <= state_d;
         orow_q    <= orow_d;
         ocol_q    <= ocol_d;
         kr_q      <= kr_d;
         kc_q      <= kc_d;
         busy      <= busy_d;
         done      <= done_d;
         mac_en    <= mac_en_d;
         mac_clr   <= mac_clr_d;
         out_valid <= out_valid_d;
         ifm_addr  <= ifm_addr_d;
         wgt_addr  <= wgt_addr_d;
         out_addr  <= out_addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      orow_d  = orow_q;
      ocol_d  = ocol_q;
      kr_d    = kr_q;
      kc_d    = kc_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_MAC;
               orow_d  = '0;
               ocol_d  = '0;
               kr_d    = '0;
               kc_d    = '0;
            end
         end
         S_MAC: begin
            if (kc_q == KLAST) begin
               kc_d = '0;
               if (kr_q == KLAST) begin
                  kr_d    = '0;
                  state_d = S_OUT;
               end else begin
                  kr_d = kr_q + WADDR_W'(1);
               end
            end else begin
               kc_d = kc_q + WADDR_W'(1);
            end
         end
         S_OUT: begin
            if (out_ready) begin
               if (orow_q == OHLAST && ocol_q == OWLAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_MAC;
                  if (ocol_q == OWLAST) begin
                     ocol_d = '0;
                     orow_d = orow_q + ADDR_W'(1);
                  end else begin
                     ocol_d = ocol_q + ADDR_W'(1);
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state/counters so they register alongside them.
   always_comb begin
      busy_d      = (state_d == S_MAC) || (state_d == S_OUT);
      done_d      = (state_d == S_DONE);
      mac_en_d    = (state_d == S_MAC);
      mac_clr_d   = 1'b0;
      out_valid_d = (state_d == S_OUT);
      ifm_addr_d  = '0;
      wgt_addr_d  = '0;
      out_addr_d  = '0;
      if (state_d == S_MAC) begin
         mac_clr_d  = (kr_d == '0) && (kc_d == '0);
         ifm_addr_d = (orow_d + ADDR_W'(kr_d)) * ADDR_W'(IMG_W) + ocol_d + ADDR_W'(kc_d);
         wgt_addr_d = kr_d * WADDR_W'(K) + kc_d;
      end
      if (state_d == S_OUT) begin
         out_addr_d = orow_d * ADDR_W'(OW) + ocol_d;
      end
   end

`ifdef CONV_SEQ_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (state_q == S_IDLE && start) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: expected taps/pixels queued at start, compared as the DUT produces them.
module tb_conv_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, out_ready;
   logic       busy, done, mac_en, mac_clr, out_valid;
   logic [7:0] ifm_addr, out_addr;
   logic [3:0] wgt_addr;
`ifdef CONV_SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   conv_seq_ctrl #(.IMG_W(8), .IMG_H(8), .K(3), .ADDR_W(8), .WADDR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .ifm_addr  (ifm_addr),
      .wgt_addr  (wgt_addr),
      .mac_en    (mac_en),
      .mac_clr   (mac_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr)
`ifdef CONV_SEQ_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] ifm;
      logic [3:0] wgt;
      logic       clr;
   } tap_t;

   tap_t tap_q[$];
   int   pix_q[$];
   tap_t exp_tap;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   mac_seen = 0;
   int   out_seen = 0;
   bit   mon_en   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_run();
      tap_t t;
      mac_seen = 0;
      out_seen = 0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) begin
            for (int kr = 0; kr < 3; kr++)
               for (int kc = 0; kc < 3; kc++) begin
                  t.ifm = 8'((r + kr) * 8 + c + kc);
                  t.wgt = 4'(kr * 3 + kc);
                  t.clr = (kr == 0 && kc == 0);
                  tap_q.push_back(t);
               end
            pix_q.push_back(r * 6 + c);
         end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (mac_en) begin
            mac_seen++;
            if (tap_q.size() == 0) check("mac_unexpected", 1, 0);
            else begin
               exp_tap = tap_q.pop_front();
               check("ifm_addr", 32'(ifm_addr), 32'(exp_tap.ifm));
               check("wgt_addr", 32'(wgt_addr), 32'(exp_tap.wgt));
               check("mac_clr", 32'(mac_clr), 32'(exp_tap.clr));
            end
            check("mac_with_valid", 32'(out_valid), 0);
         end else if (out_valid) begin
            check("clr_without_en", 32'(mac_clr), 0);
            if (pix_q.size() == 0) check("pix_unexpected", 1, 0);
            else begin
               check("out_addr", 32'(out_addr), 32'(pix_q[0]));
               if (out_ready) begin
                  void'(pix_q.pop_front());
                  out_seen++;
               end
            end
         end else begin
            check("idle_addrs", {12'd0, ifm_addr, wgt_addr, out_addr, mac_clr}, 0);
         end
      end
   end

   // Called one cycle before the run's cycle 0; leaves the bench in the cycle after done.
   task automatic do_run(input int stall_at, input int stall_len, input int busy_start,
                         input bit start_in_done, input int exp_done);
      int n;
      bit seen;
      push_run();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      seen = 1'b0;
      check("first_mac", {31'd0, mac_en & mac_clr}, 1);
      while (n <= 2000 && !seen) begin
         out_ready = !(n >= stall_at && n < stall_at + stall_len);
         if (n >= stall_at && n < stall_at + stall_len) check("bp_valid", 32'(out_valid), 1);
         if (done) begin
            seen = 1'b1;
            check("done_cycle", n, exp_done);
            check("busy_in_done", 32'(busy), 0);
            start = start_in_done;
         end else begin
            if (n % 50 == 1) check("busy_during_run", 32'(busy), 1);
            start = (n == busy_start);
            @(posedge clk); #1;
            n++;
         end
      end
      if (!seen) check("done_timeout", 0, 1);
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = 1'b1;
      check("busy_after_done", 32'(busy), 0);
      check("done_one_cycle", 32'(done), 0);
      check("mac_count", mac_seen, 324);
      check("out_count", out_seen, 36);
      check("taps_left", tap_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {27'd0, busy, done, mac_en, mac_clr, out_valid}, 0);
      check("rst_addrs", {12'd0, ifm_addr, wgt_addr, out_addr}, 0);
      rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      do_run(0, 0, 0, 1'b1, 361);
      do_run(0, 0, 50, 1'b0, 361);
      repeat (2) @(posedge clk);
      #1;
      do_run(10, 3, 0, 1'b0, 364);
`ifdef CONV_SEQ_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 3);
`endif

      push_run();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n < 100; n++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_ctrl", {27'd0, busy, done, mac_en, mac_clr, out_valid}, 0);
      check("midrst_addrs", {12'd0, ifm_addr, wgt_addr, out_addr}, 0);
      tap_q.delete();
      pix_q.delete();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("midrst_quiet", {30'd0, busy, done}, 0);
      end
      do_run(0, 0, 0, 1'b0, 361);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
